// File: rtl/matrix_result_streamer.sv
// Serialises a 2x2 matrix product into a valid/ready element stream.
// One active slot plus one pending slot absorb back-to-back done pulses.
module matrix_result_streamer #(
  parameter int DATA_W    = 16,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_in,
  input  logic [DATA_W-1:0] c11_in,
  input  logic [DATA_W-1:0] c12_in,
  input  logic [DATA_W-1:0] c21_in,
  input  logic [DATA_W-1:0] c22_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_index,
  output logic              m_last,
  output logic              busy,
  input  logic              ovf_clr,
  output logic              overflow
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [1:0]        beat;
  logic              pend_full, pend_full_nxt;
  logic [DATA_W-1:0] act_c  [4];
  logic [DATA_W-1:0] pend_c [4];

  logic xfer, fin;
  logic load_act_new, load_act_pend, load_pend, ovf_set;

  // Slot index of the element emitted on a given beat; column order swaps C12/C21.
  function automatic logic [1:0] elem_pos(input logic [1:0] b);
    return COL_MAJOR ? {b[0], b[1]} : b;
  endfunction

  always_comb begin
    xfer          = m_valid && m_ready;
    fin           = xfer && (beat == 2'd3);
    load_act_new  = done_in && ((state == IDLE) || (fin && !pend_full));
    load_act_pend = fin && pend_full;
    load_pend     = done_in && (state == STREAM) &&
                    ((fin && pend_full) || (!fin && !pend_full));
    ovf_set       = done_in && (state == STREAM) && !fin && pend_full;
    pend_full_nxt = pend_full;
    if (load_pend)          pend_full_nxt = 1'b1;
    else if (load_act_pend) pend_full_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (done_in) state_nxt = STREAM;
      STREAM:  if (fin && !pend_full && !done_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid = (state == STREAM);
    m_index = beat;
    m_last  = m_valid && (beat == 2'd3);
    m_data  = m_valid ? act_c[elem_pos(beat)] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat      <= 2'd0;
      pend_full <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (fin || load_act_new) beat <= 2'd0;
      else if (xfer)           beat <= beat + 2'd1;
      pend_full <= pend_full_nxt;
      // A dropped matrix on the same edge as a clear keeps the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      busy <= (state_nxt == STREAM) || pend_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_act_new) begin
      act_c[0] <= c11_in;
      act_c[1] <= c12_in;
      act_c[2] <= c21_in;
      act_c[3] <= c22_in;
    end else if (load_act_pend) begin
      act_c <= pend_c;
    end
    if (load_pend) begin
      pend_c[0] <= c11_in;
      pend_c[1] <= c12_in;
      pend_c[2] <= c21_in;
      pend_c[3] <= c22_in;
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed and randomized bench for matrix_result_streamer, comparing a
// row-major and a column-major instance against a beat-queue reference model.
module tb_matrix_result_streamer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, done_in, m_ready, ovf_clr;
  logic [DW-1:0] c11, c12, c21, c22;

  logic          vld_r, last_r, busy_r, ovf_r;
  logic [DW-1:0] data_r;
  logic [1:0]    idx_r;
  logic          vld_c, last_c, busy_c, ovf_c;
  logic [DW-1:0] data_c;
  logic [1:0]    idx_c;

  always #5 clk = ~clk;

  matrix_result_streamer #(.DATA_W(DW), .COL_MAJOR(1'b0)) dut_rm (
    .clk(clk), .rst(rst), .done_in(done_in),
    .c11_in(c11), .c12_in(c12), .c21_in(c21), .c22_in(c22),
    .m_valid(vld_r), .m_ready(m_ready), .m_data(data_r), .m_index(idx_r),
    .m_last(last_r), .busy(busy_r), .ovf_clr(ovf_clr), .overflow(ovf_r));

  matrix_result_streamer #(.DATA_W(DW), .COL_MAJOR(1'b1)) dut_cm (
    .clk(clk), .rst(rst), .done_in(done_in),
    .c11_in(c11), .c12_in(c12), .c21_in(c21), .c22_in(c22),
    .m_valid(vld_c), .m_ready(m_ready), .m_data(data_c), .m_index(idx_c),
    .m_last(last_c), .busy(busy_c), .ovf_clr(ovf_clr), .overflow(ovf_c));

  // Reference model: every beat still owed to the consumer, oldest first.
  typedef struct packed {
    logic [4*DW-1:0] mat;
    logic [1:0]      beat;
  } beat_t;

  beat_t q[$];
  logic  ovf_m;
  int    checks = 0;
  int    failures = 0;
  int    col_ord[4] = '{0, 2, 1, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int    occ;
    logic  xfer, fin, ovf_set;
    beat_t e;
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
      return;
    end
    occ     = (q.size() + 3) / 4;
    xfer    = (q.size() != 0) && m_ready;
    fin     = xfer && (q[0].beat == 2'd3);
    ovf_set = 1'b0;
    if (xfer) void'(q.pop_front());
    if (done_in) begin
      if (occ < 2 || fin) begin
        for (int b = 0; b < 4; b++) begin
          e.mat  = {c22, c21, c12, c11};
          e.beat = b[1:0];
          q.push_back(e);
        end
      end else begin
        ovf_set = 1'b1;
      end
    end
    if (ovf_set)      ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
  endtask

  task automatic check_all();
    logic          v;
    logic [DW-1:0] er, ec;
    v = (q.size() != 0);
    chk("valid_rm", 32'(vld_r), 32'(v));
    chk("valid_cm", 32'(vld_c), 32'(v));
    chk("busy_rm", 32'(busy_r), 32'(v));
    chk("busy_cm", 32'(busy_c), 32'(v));
    chk("overflow_rm", 32'(ovf_r), 32'(ovf_m));
    chk("overflow_cm", 32'(ovf_c), 32'(ovf_m));
    if (v) begin
      er = q[0].mat[int'(q[0].beat)*DW +: DW];
      ec = q[0].mat[col_ord[q[0].beat]*DW +: DW];
      chk("data_rm", 32'(data_r), 32'(er));
      chk("data_cm", 32'(data_c), 32'(ec));
      chk("index_rm", 32'(idx_r), 32'(q[0].beat));
      chk("index_cm", 32'(idx_c), 32'(q[0].beat));
      chk("last_rm", 32'(last_r), 32'(q[0].beat == 2'd3));
      chk("last_cm", 32'(last_c), 32'(q[0].beat == 2'd3));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_outputs_zero();
    chk("rst_data_rm", 32'(data_r), 32'd0);
    chk("rst_data_cm", 32'(data_c), 32'd0);
    chk("rst_index", 32'(idx_r), 32'd0);
    chk("rst_last", 32'(last_r), 32'd0);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    done_in = 1'b1;
    c11 = DW'(a); c12 = DW'(b); c21 = DW'(c); c22 = DW'(d);
    step();
    done_in = 1'b0;
    c11 = DW'($urandom); c12 = DW'($urandom); c21 = DW'($urandom); c22 = DW'($urandom);
  endtask

  initial begin
    int rdy_pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    rst = 1'b1; done_in = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    ovf_m = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    idle_outputs_zero();

    // Single matrix, consumer always ready.
    m_ready = 1'b1;
    send(31, 36, 27, 32);
    repeat (5) step();

    // Backpressure pattern while one matrix drains.
    send(31, 36, 27, 32);
    for (int i = 0; i < 14; i++) begin
      m_ready = rdy_pat[i % 7][0];
      step();
    end
    m_ready = 1'b1;
    repeat (2) step();

    // Second done during beat 1 of the first matrix.
    send(31, 36, 27, 32);
    step();
    send(19, 22, 43, 50);
    repeat (8) step();

    // Three matrices against a stalled consumer: the third is dropped.
    m_ready = 1'b0;
    send(101, 102, 103, 104);
    step();
    send(201, 202, 203, 204);
    step();
    send(301, 302, 303, 304);
    step();
    chk("ovf_after_third", 32'(ovf_r), 32'd1);
    m_ready = 1'b1;
    repeat (10) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf_r), 32'd0);

    // Reset in the middle of a stream with the pending slot full.
    send(5, 6, 7, 8);
    send(9, 10, 11, 12);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(vld_r), 32'd0);
    chk("midrst_busy", 32'(busy_r), 32'd0);
    chk("midrst_ovf", 32'(ovf_r), 32'd0);
    idle_outputs_zero();
    send(1, 2, 3, 4);
    repeat (6) step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom % 150) == 0;
      done_in = ($urandom % 4) == 0;
      m_ready = ($urandom % 3) != 0;
      ovf_clr = ($urandom % 25) == 0;
      c11 = DW'($urandom); c12 = DW'($urandom);
      c21 = DW'($urandom); c22 = DW'($urandom);
      step();
    end
    rst = 1'b0; done_in = 1'b0; ovf_clr = 1'b0; m_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Drains the 2x2 product from the team's matrix multiply FSM (parallel C11..C22 plus a one-cycle done pulse) into a serial valid/ready element stream for downstream consumers (UART bridge, memory writer).
- Provides one active slot plus one pending slot, so a back-to-back multiply result is not lost while the previous matrix is still streaming.
- Beats are emitted in a configurable order and flagged with last on element 3.

Parameters:
- DATA_W, 16, width of each C element and of m_data.
- COL_MAJOR, 0, element order. 0 = C11, C12, C21, C22. 1 = C11, C21, C12, C22.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- done_in  input  1  one-cycle pulse from the multiplier; C inputs are valid in the same cycle.
- c11_in  input  DATA_W  product element (1,1).
- c12_in  input  DATA_W  product element (1,2).
- c21_in  input  DATA_W  product element (2,1).
- c22_in  input  DATA_W  product element (2,2).
- m_valid  output  1  m_data/m_index/m_last hold a valid beat.
- m_ready  input  1  consumer accepts the beat.
- m_data  output  DATA_W  current element.
- m_index  output  2  beat number 0..3 within the matrix (not the element position).
- m_last  output  1  high on beat 3.
- busy  output  1  active slot or pending slot occupied.
- overflow  output  1  sticky; a done_in was dropped because both slots were full.
- ovf_clr  input  1  clears overflow on the next edge.

Behaviour:
- Reset: evaluated only on a clk edge with rst=1. It overrides every other input, including mid-stream.
  - Next cycle: m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, overflow=0.
  - Both slots are emptied and the FSM goes to IDLE.
- Transfer rule: a beat transfers on an edge where m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable.
  - m_valid never drops without a transfer.
- FSM state IDLE (active slot empty, m_valid=0):
  - done_in=1 at edge N latches c11..c22 into the active slot, sets beat=0 and moves to STREAM.
  - m_valid=1 in cycle N+1, giving one cycle latency from done_in to the first beat.
- FSM state STREAM (m_valid=1):
  - On a transfer with beat<3: beat increments.
  - On a transfer with beat=3 (m_last=1) and the pending slot full: pending moves to active, beat=0, stay in STREAM. m_valid stays high, so there is no bubble.
  - On a transfer with beat=3 and the pending slot empty: go to IDLE and drop m_valid.
- Data mapping: m_data = element selected by beat through the COL_MAJOR order. m_last = (beat==3). m_index = beat.
- done_in while in STREAM:
  - Pending slot empty: capture into pending.
  - Pending slot full: discard the new matrix and set overflow=1.
- Simultaneous events (done_in on the same edge as a beat-3 transfer):
  - Pending empty: the new matrix loads directly into active, beat=0, m_valid stays 1 with no bubble. No overflow.
  - Pending full: pending moves to active and the new matrix enters pending. No overflow.
  - Any other state with done_in, pending full and no final transfer: overflow=1.
- Overflow control: overflow clears only on rst or ovf_clr. If ovf_clr and an overflow event occur on the same edge, the set wins.
- busy: registered; equals (active occupied || pending occupied).
- Width rules: elements are passed through unmodified with no truncation.
- Input timing: c*_in are ignored in cycles without done_in.

Test Plan:
- Reset, then pulse done_in with C = 31, 36, 27, 32 and hold m_ready=1.
  - Expect m_valid from the next cycle, with beats 31, 36, 27, 32 on consecutive cycles.
  - Expect m_index 0..3 and m_last only on 32.
  - Then m_valid=0 and busy=0.
- Same input with COL_MAJOR=1 -> beats 31, 27, 36, 32.
- Backpressure: toggle m_ready 1,0,0,1,0,1,1 -> each beat holds stable while stalled; the order is still 31, 36, 27, 32 and no beat is duplicated.
- Back-to-back: send a second done_in (C = 19, 22, 43, 50) during beat 1 of the first matrix, with m_ready=1.
  - Expect 8 contiguous beats 31, 36, 27, 32, 19, 22, 43, 50 with no bubble and m_last on 32 and 50.
  - overflow stays 0.
- Overflow: with m_ready=0, pulse done_in three times (matrices X, Y, Z).
  - overflow=1 after the third pulse.
  - Releasing m_ready streams X then Y only.
  - ovf_clr clears overflow.
- Reset mid-stream: assert rst during beat 2 with pending full -> next cycle m_valid=0, busy=0, overflow=0. A following done_in with 1, 2, 3, 4 streams cleanly from beat 0.
